// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Sends one command byte to the keyboard over the shared ps2_clk/ps2_data
// pins, which are driven open-drain through output enables (1 = pull low).
// Optional build macro: PS2_TX_RETRY_EN -- after an ACK error or timeout the
// latched byte is resent, up to two more times, before O_ERROR is reported.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus released, waiting for I_START
// INHIBIT   | ps2_clk held low before the request-to-send
// RTS       | start bit driven, ps2_clk released, timeout timer armed
// SHIFT     | D0..D7, parity, stop advanced on device clk falling edges
// STOP      | stop bit (released data) on the line, waiting for next edge
// ACK       | waiting for the ACK edge; filtered data must read low
// WAITIDLE  | waiting for both lines to return high
// FINISH    | one-cycle DONE or ERROR pulse; busy already low

module ps2_host_tx #(
    parameter int CLK_KHZ    = 24390,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 15,
    parameter int FILT_LEN   = 8
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic [7:0] I_DATA,
    input  logic       I_START,
    output logic       O_BUSY,
    output logic       O_DONE,
    output logic       O_ERROR,
    input  logic       I_PS2_CLK,
    input  logic       I_PS2_DATA,
    output logic       O_PS2_CLK_OE,
    output logic       O_PS2_DATA_OE
);

    localparam int INH_CYC = INHIBIT_US * CLK_KHZ / 1000;
    localparam int TO_CYC  = TIMEOUT_MS * CLK_KHZ;
    localparam logic [31:0] INH_LOAD = 32'(INH_CYC - 1);
    localparam logic [31:0] TO_LOAD  = 32'(TO_CYC - 1);
    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FW-1:0] FILT_LOAD = FW'(FILT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_STOP,
        S_ACK,
        S_WAITIDLE,
        S_FINISH
    } state_t;

    state_t state, state_n;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt, data_filt, clk_filt_d;
    logic [FW-1:0] clk_fcnt, data_fcnt;
    logic          clk_fall;

    logic [10:0]   sr;
    logic [3:0]    bit_cnt;
    logic [31:0]   inh_cnt;
    logic [31:0]   to_cnt;
    logic          fin_err;
    logic [7:0]    frame_byte;

    logic ld_frame, ld_inh, ld_to, do_shift, fail, finish_ok;
    logic busy, done, err, clk_oe, data_oe;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] retry_cnt;
    logic [7:0] frame_q;
    logic       retry;
`endif

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], I_PS2_CLK};
            data_sync <= {data_sync[0], I_PS2_DATA};
        end
    end

    // ps2_clk filter: a new level is accepted after FILT_LEN stable cycles.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            clk_filt <= 1'b1;
            clk_fcnt <= FILT_LOAD;
        end else if (clk_sync[1] == clk_filt) begin
            clk_fcnt <= FILT_LOAD;
        end else if (clk_fcnt == '0) begin
            clk_filt <= clk_sync[1];
            clk_fcnt <= FILT_LOAD;
        end else begin
            clk_fcnt <= clk_fcnt - 1'b1;
        end
    end

    // ps2_data filter, same scheme as the clock filter.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            data_filt <= 1'b1;
            data_fcnt <= FILT_LOAD;
        end else if (data_sync[1] == data_filt) begin
            data_fcnt <= FILT_LOAD;
        end else if (data_fcnt == '0) begin
            data_filt <= data_sync[1];
            data_fcnt <= FILT_LOAD;
        end else begin
            data_fcnt <= data_fcnt - 1'b1;
        end
    end

    // Delayed filtered clock for falling-edge detection.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            clk_filt_d <= 1'b1;
        end else begin
            clk_filt_d <= clk_filt;
        end
    end

    assign clk_fall = clk_filt_d & ~clk_filt;

`ifdef PS2_TX_RETRY_EN
    assign frame_byte = (state == S_IDLE) ? I_DATA : frame_q;
`else
    assign frame_byte = I_DATA;
`endif

    // State register.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, datapath strobes and pin/status outputs.
    always_comb begin
        state_n   = state;
        ld_frame  = 1'b0;
        ld_inh    = 1'b0;
        ld_to     = 1'b0;
        do_shift  = 1'b0;
        fail      = 1'b0;
        finish_ok = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        clk_oe    = 1'b0;
        data_oe   = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (I_START) begin
                    ld_frame = 1'b1;
                    ld_inh   = 1'b1;
                    state_n  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_oe = 1'b1;
                if (inh_cnt == '0) begin
                    ld_to   = 1'b1;
                    state_n = S_RTS;
                end
            end
            S_RTS: begin
                data_oe = ~sr[0];
                state_n = S_SHIFT;
            end
            S_SHIFT: begin
                data_oe = ~sr[0];
                if (to_cnt == '0) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    do_shift = 1'b1;
                    // Edge 10 puts the stop bit (a release) on the line.
                    if (bit_cnt == 4'd9) begin
                        state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (to_cnt == '0) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    state_n = S_ACK;
                end
            end
            S_ACK: begin
                if (to_cnt == '0) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    if (data_filt) begin
                        fail = 1'b1;
                    end else begin
                        state_n = S_WAITIDLE;
                    end
                end
            end
            S_WAITIDLE: begin
                if (clk_filt && data_filt) begin
                    finish_ok = 1'b1;
                    state_n   = S_FINISH;
                end
            end
            S_FINISH: begin
                busy    = 1'b0;
                done    = ~fin_err;
                err     = fin_err;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (retry_cnt != 2'd2) begin
                retry    = 1'b1;
                ld_frame = 1'b1;
                ld_inh   = 1'b1;
                state_n  = S_INHIBIT;
            end else begin
                state_n = S_FINISH;
            end
`else
            state_n = S_FINISH;
`endif
        end
    end

    // Frame shift register, bit counter, timers and the outcome flag.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            sr      <= '0;
            bit_cnt <= '0;
            inh_cnt <= '0;
            to_cnt  <= '0;
            fin_err <= 1'b0;
        end else begin
            if (ld_frame) begin
                sr      <= {1'b1, ~^frame_byte, frame_byte, 1'b0};
                bit_cnt <= '0;
            end else if (do_shift) begin
                sr <= {1'b1, sr[10:1]};
                if (bit_cnt != 4'd10) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end

            if (ld_inh) begin
                inh_cnt <= INH_LOAD;
            end else if (state == S_INHIBIT && inh_cnt != '0) begin
                inh_cnt <= inh_cnt - 32'd1;
            end

            // Timeout covers request-to-send through the ACK edge.
            if (ld_to) begin
                to_cnt <= TO_LOAD;
            end else if ((state == S_RTS || state == S_SHIFT || state == S_STOP ||
                          state == S_ACK) && to_cnt != '0) begin
                to_cnt <= to_cnt - 32'd1;
            end

            if (fail) begin
                fin_err <= 1'b1;
            end else if (finish_ok) begin
                fin_err <= 1'b0;
            end
        end
    end

`ifdef PS2_TX_RETRY_EN
    // Latched byte and retry count for automatic resends.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            retry_cnt <= '0;
            frame_q   <= '0;
        end else if (state == S_IDLE && ld_frame) begin
            retry_cnt <= '0;
            frame_q   <= I_DATA;
        end else if (retry) begin
            retry_cnt <= retry_cnt + 2'd1;
        end
    end
`endif

    assign O_BUSY        = busy;
    assign O_DONE        = done;
    assign O_ERROR       = err;
    assign O_PS2_CLK_OE  = clk_oe;
    assign O_PS2_DATA_OE = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame, frame bits
// expected on the line are queued at start and compared as they are sampled.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int CLK_KHZ    = 1000;
    localparam int INHIBIT_US = 120;
    localparam int TIMEOUT_MS = 15;
    localparam int FILT_LEN   = 8;
    localparam int INH_EXP    = 120;
    localparam int TO_EXP     = 15000;
    localparam int HALF       = 40;
`ifdef PS2_TX_RETRY_EN
    localparam int TRIES = 3;
`else
    localparam int TRIES = 1;
`endif

    logic       I_CLK = 1'b0;
    logic       I_RESET = 1'b1;
    logic [7:0] I_DATA = 8'h00;
    logic       I_START = 1'b0;
    logic       O_BUSY, O_DONE, O_ERROR, O_PS2_CLK_OE, O_PS2_DATA_OE;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    int   n_err = 0;
    logic busy_at_pulse = 1'b0;
    bit   exp_bits[$];

    assign ps2_clk_line  = ~(O_PS2_CLK_OE | dev_clk_low);
    assign ps2_data_line = ~(O_PS2_DATA_OE | dev_data_low);

    ps2_host_tx #(
        .CLK_KHZ(CLK_KHZ), .INHIBIT_US(INHIBIT_US),
        .TIMEOUT_MS(TIMEOUT_MS), .FILT_LEN(FILT_LEN)
    ) dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_DATA(I_DATA), .I_START(I_START),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERROR(O_ERROR),
        .I_PS2_CLK(ps2_clk_line), .I_PS2_DATA(ps2_data_line),
        .O_PS2_CLK_OE(O_PS2_CLK_OE), .O_PS2_DATA_OE(O_PS2_DATA_OE)
    );

    always #5 I_CLK = ~I_CLK;

    // Pulse monitor.
    always @(negedge I_CLK) begin
        if (O_DONE) begin
            n_done++;
            busy_at_pulse = O_BUSY;
        end
        if (O_ERROR) begin
            n_err++;
            busy_at_pulse = O_BUSY;
        end
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge I_CLK);
    endtask

    task automatic push_frame(input logic [7:0] b);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        exp_bits.push_back(($countones(b) % 2) == 0);
        exp_bits.push_back(1'b1);
    endtask

    task automatic do_start(input logic [7:0] b);
        I_DATA = b;
        I_START = 1'b1;
        cyc(1);
        I_START = 1'b0;
        push_frame(b);
        checks++;
        if (O_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: busy=%b, required 1", O_BUSY);
        end
    endtask

    task automatic wait_rts(output int inh);
        int n;
        n = 0;
        inh = 0;
        while (O_PS2_CLK_OE !== 1'b1 && n < 5000) begin
            cyc(1);
            n++;
        end
        while (O_PS2_CLK_OE === 1'b1 && inh < 1000) begin
            inh++;
            cyc(1);
        end
        checks++;
        if (O_PS2_DATA_OE !== 1'b1 || O_PS2_CLK_OE !== 1'b0) begin
            errors++;
            $display("FAIL rts: clk_oe=%b data_oe=%b, required 0/1", O_PS2_CLK_OE, O_PS2_DATA_OE);
        end
    endtask

    task automatic device_clock(input int n_edges, input bit ack, input int glitch_k);
        bit   exp_b;
        logic got;
        cyc(20);
        for (int k = 1; k <= n_edges; k++) begin
            if (k <= 11) begin
                got = ps2_data_line;
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL frame_bit%0d: got %b, nothing expected", k, got);
                end else begin
                    exp_b = exp_bits.pop_front();
                    if (got !== exp_b) begin
                        errors++;
                        $display("FAIL frame_bit%0d: got %b, required %b", k, got, exp_b);
                    end
                end
            end
            dev_clk_low = 1'b1;
            cyc(HALF);
            if (k == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b0;
            if (k == glitch_k) begin
                cyc(15);
                dev_clk_low = 1'b1;
                cyc(3);
                dev_clk_low = 1'b0;
                cyc(HALF - 18);
            end else begin
                cyc(HALF);
            end
            if (k == 12) dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_pulse(input int base);
        int n;
        n = 0;
        while ((n_done + n_err) <= base && n < 2000) begin
            cyc(1);
            n++;
        end
        checks++;
        if ((n_done + n_err) <= base) begin
            errors++;
            $display("FAIL pulse_wait: no DONE/ERROR within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        I_RESET = 1'b1;
        cyc(3);
        checks++;
        if ({O_BUSY, O_DONE, O_ERROR, O_PS2_CLK_OE, O_PS2_DATA_OE} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {O_BUSY, O_DONE, O_ERROR, O_PS2_CLK_OE, O_PS2_DATA_OE});
        end
        I_RESET = 1'b0;
        cyc(5);
        checks++;
        if ({O_BUSY, O_PS2_CLK_OE, O_PS2_DATA_OE} !== 3'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, required 000",
                     {O_BUSY, O_PS2_CLK_OE, O_PS2_DATA_OE});
        end
    endtask

    task automatic test_frame(input logic [7:0] b, input int glitch_k);
        int bd, be, inh;
        bd = n_done;
        be = n_err;
        do_start(b);
        wait_rts(inh);
        checks++;
        if (inh != INH_EXP) begin
            errors++;
            $display("FAIL inhibit_len: %0d cycles, required %0d", inh, INH_EXP);
        end
        device_clock(12, 1'b1, glitch_k);
        wait_pulse(bd + be);
        cyc(5);
        checks++;
        if (n_done - bd != 1 || n_err - be != 0) begin
            errors++;
            $display("FAIL frame_%h_result: done=%0d err=%0d, required 1/0", b, n_done - bd, n_err - be);
        end
        checks++;
        if (busy_at_pulse !== 1'b0 || O_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL busy_end: at pulse=%b now=%b, required 0/0", busy_at_pulse, O_BUSY);
        end
        checks++;
        if (exp_bits.size() != 0) begin
            errors++;
            $display("FAIL frame_bits_left: %0d, required 0", exp_bits.size());
        end
        exp_bits.delete();
    endtask

    task automatic test_timeout();
        int be, inh, n;
        be = n_err;
        do_start(8'h55);
        exp_bits.delete();
        for (int t = 0; t < TRIES; t++) begin
            wait_rts(inh);
            n = 0;
            while (O_ERROR !== 1'b1 && O_PS2_CLK_OE !== 1'b1 && n < 20000) begin
                cyc(1);
                n++;
            end
            checks++;
            if (n != TO_EXP) begin
                errors++;
                $display("FAIL timeout_len: %0d cycles, required %0d", n, TO_EXP);
            end
            checks++;
            if (t == TRIES - 1) begin
                if ({O_ERROR, O_PS2_CLK_OE, O_PS2_DATA_OE} !== 3'b100) begin
                    errors++;
                    $display("FAIL timeout_end: err/clk_oe/data_oe=%b, required 100",
                             {O_ERROR, O_PS2_CLK_OE, O_PS2_DATA_OE});
                end
            end else if (O_ERROR !== 1'b0) begin
                errors++;
                $display("FAIL timeout_retry: err=%b, required 0", O_ERROR);
            end
        end
        cyc(5);
        checks++;
        if (n_err - be != 1) begin
            errors++;
            $display("FAIL timeout_count: %0d error pulses, required 1", n_err - be);
        end
    endtask

    task automatic test_nack();
        int bd, be, inh;
        bd = n_done;
        be = n_err;
        do_start(8'hF0);
        for (int t = 0; t < TRIES; t++) begin
            if (t > 0) push_frame(8'hF0);
            wait_rts(inh);
            checks++;
            if (n_err != be) begin
                errors++;
                $display("FAIL nack_early_error: %0d pulses before frame %0d, required 0", n_err - be, t + 1);
            end
            device_clock(12, 1'b0, 0);
        end
        wait_pulse(bd + be);
        cyc(5);
        checks++;
        if (n_err - be != 1 || n_done - bd != 0) begin
            errors++;
            $display("FAIL nack_result: err=%0d done=%0d, required 1/0", n_err - be, n_done - bd);
        end
        checks++;
        if (busy_at_pulse !== 1'b0) begin
            errors++;
            $display("FAIL nack_busy: busy at pulse=%b, required 0", busy_at_pulse);
        end
        exp_bits.delete();
    endtask

    task automatic test_reset_midframe();
        int bd, be, inh;
        bd = n_done;
        be = n_err;
        do_start(8'h3C);
        wait_rts(inh);
        device_clock(5, 1'b1, 0);
        exp_bits.delete();
        I_RESET = 1'b1;
        cyc(1);
        I_RESET = 1'b0;
        checks++;
        if ({O_BUSY, O_PS2_CLK_OE, O_PS2_DATA_OE} !== 3'b000) begin
            errors++;
            $display("FAIL midframe_reset: busy/clk_oe/data_oe=%b, required 000",
                     {O_BUSY, O_PS2_CLK_OE, O_PS2_DATA_OE});
        end
        cyc(30);
        checks++;
        if (n_done != bd || n_err != be) begin
            errors++;
            $display("FAIL midframe_pulses: done=%0d err=%0d, required 0/0", n_done - bd, n_err - be);
        end
        test_frame(8'hFF, 0);
    endtask

    task automatic test_back_to_back();
        int bd, inh, n;
        bd = n_done;
        do_start(8'h12);
        cyc(10);
        I_DATA = 8'h99;
        I_START = 1'b1;
        cyc(1);
        I_START = 1'b0;
        wait_rts(inh);
        device_clock(12, 1'b1, 0);
        n = 0;
        while (O_DONE !== 1'b1 && n < 2000) begin
            cyc(1);
            n++;
        end
        checks++;
        if (O_DONE !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: done=%b after %0d cycles, required 1", O_DONE, n);
        end
        I_DATA = 8'h77;
        I_START = 1'b1;
        cyc(1);
        I_START = 1'b0;
        checks++;
        if (O_BUSY !== 1'b0 || O_PS2_CLK_OE !== 1'b0) begin
            errors++;
            $display("FAIL start_on_pulse: busy=%b clk_oe=%b, required 0/0", O_BUSY, O_PS2_CLK_OE);
        end
        do_start(8'h81);
        wait_rts(inh);
        checks++;
        if (inh != INH_EXP) begin
            errors++;
            $display("FAIL b2b_inhibit_len: %0d cycles, required %0d", inh, INH_EXP);
        end
        device_clock(12, 1'b1, 0);
        wait_pulse(n_done + n_err - 1);
        cyc(300);
        checks++;
        if (n_done - bd != 2 || O_BUSY !== 1'b0 || O_PS2_CLK_OE !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: done=%0d busy=%b clk_oe=%b, required 2/0/0",
                     n_done - bd, O_BUSY, O_PS2_CLK_OE);
        end
        checks++;
        if (exp_bits.size() != 0) begin
            errors++;
            $display("FAIL b2b_bits_left: %0d, required 0", exp_bits.size());
        end
        exp_bits.delete();
    endtask

    initial begin
        @(negedge I_CLK);
        test_reset();
        test_frame(8'hF4, 0);
        test_frame(8'hED, 0);
        test_timeout();
        cyc(50);
        test_nack();
        cyc(50);
        test_frame(8'hA5, 5);
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
